// File: rtl/ddr_test_uart_pkg.sv
// ddr_test_uart_pkg: shared constants and state types for the UART command front-end
// Contents: frame start byte, command codes, receiver/parser state enums, checksum helper.
package ddr_test_uart_pkg;
    localparam logic [7:0] SOF_BYTE        = 8'hA5;
    localparam logic [7:0] CMD_START       = 8'h01;
    localparam logic [7:0] CMD_STOP        = 8'h02;
    localparam logic [7:0] CMD_SET_PATTERN = 8'h03;
    localparam logic [7:0] CMD_CLR_ERR     = 8'h04;

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [2:0] {P_SOF, P_CMD, P_ARGH, P_ARGL, P_CHK} parser_state_t;

    function automatic logic [7:0] frame_chk(input logic [7:0] c, input logic [7:0] a, input logic [7:0] b);
        return c ^ a ^ b;
    endfunction
endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 byte receiver with input synchronizer and baud/bit counters
// Ports: clk_i, rst_ni (async low), rxd_i serial in; byte_valid_o/byte_data_o one-cycle byte strobe,
// frame_err_o one-cycle bad-stop strobe, idle_o high while waiting for a start bit.
module uart_rx_byte
    import ddr_test_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rxd_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o,
    output logic       frame_err_o,
    output logic       idle_o
);
    localparam int CW   = $clog2(CLKS_PER_BIT + 1);
    localparam int HALF = CLKS_PER_BIT / 2;

    rx_state_t   state_q, state_d;
    logic [1:0]  sync_q;
    logic        prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  data_q, data_d;
    logic        byte_valid_q, byte_valid_d;
    logic        frame_err_q, frame_err_d;
    logic        rx_s, fall, tick;

    assign rx_s = sync_q[1];
    assign fall = prev_q & ~rx_s;
    // cnt_q counts down to the next sample point; zero marks a sample cycle
    assign tick = cnt_q == '0;

    always_comb begin
        state_d      = state_q;
        cnt_d        = tick ? CW'(CLKS_PER_BIT - 1) : cnt_q - CW'(1);
        bit_d        = bit_q;
        data_d       = data_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (state_q)
            R_IDLE: begin
                cnt_d = CW'(HALF - 1);
                if (fall) state_d = R_START;
            end
            R_START: if (tick) begin
                state_d = rx_s ? R_IDLE : R_DATA;
                bit_d   = '0;
            end
            R_DATA: if (tick) begin
                data_d = {rx_s, data_q[7:1]};
                bit_d  = bit_q + 3'd1;
                if (bit_q == 3'd7) state_d = R_STOP;
            end
            R_STOP: if (tick) begin
                state_d      = R_IDLE;
                byte_valid_d = rx_s;
                frame_err_d  = ~rx_s;
            end
            default: state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q       <= 2'b11;
            prev_q       <= 1'b1;
            state_q      <= R_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            data_q       <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], rxd_i};
            prev_q       <= rx_s;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            data_q       <= data_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign byte_valid_o = byte_valid_q;
    assign byte_data_o  = data_q;
    assign frame_err_o  = frame_err_q;
    assign idle_o       = state_q == R_IDLE;
endmodule

// File: rtl/ddr_test_uart_cmd.sv
// ddr_test_uart_cmd: UART command frame parser delivering checksummed commands over ready/valid
// Ports: free_clk, rst_board (async low), uart_rxd serial in; cmd_valid/cmd_ready/cmd_code/cmd_arg
// command handshake; rx_busy mid-frame flag; err_frame_cnt/err_chk_cnt saturating error counts;
// overflow sticky dropped-frame flag.
module ddr_test_uart_cmd
    import ddr_test_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic        free_clk,
    input  logic        rst_board,
    input  logic        uart_rxd,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [7:0]  cmd_code,
    output logic [15:0] cmd_arg,
    output logic        rx_busy,
    output logic [7:0]  err_frame_cnt,
    output logic [7:0]  err_chk_cnt,
    output logic        overflow
);
    localparam int TO_MAX = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW     = $clog2(TO_MAX + 1);

    logic       bv, fe, rx_idle;
    logic [7:0] bd;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk_i       (free_clk),
        .rst_ni      (rst_board),
        .rxd_i       (uart_rxd),
        .byte_valid_o(bv),
        .byte_data_o (bd),
        .frame_err_o (fe),
        .idle_o      (rx_idle)
    );

    parser_state_t ps_q, ps_d;
    logic [7:0]    cmd_q, cmd_d, argh_q, argh_d, argl_q, argl_d;
    logic [TW-1:0] to_q, to_d;
    logic          valid_q, valid_d, ovf_q, ovf_d;
    logic [7:0]    code_q, code_d, fcnt_q, fcnt_d, ccnt_q, ccnt_d;
    logic [15:0]   arg_q, arg_d;
    logic          chk_byte, frame_done, chk_bad, load;

    assign chk_byte   = bv && ps_q == P_CHK;
    assign frame_done = chk_byte && bd == frame_chk(cmd_q, argh_q, argl_q);
    assign chk_bad    = chk_byte && !frame_done;

    always_comb begin
        ps_d   = ps_q;
        cmd_d  = cmd_q;
        argh_d = argh_q;
        argl_d = argl_q;
        if (fe) ps_d = P_SOF;
        else if (bv) begin
            case (ps_q)
                P_SOF:  ps_d = bd == SOF_BYTE ? P_CMD : P_SOF;
                P_CMD:  begin cmd_d  = bd; ps_d = P_ARGH; end
                P_ARGH: begin argh_d = bd; ps_d = P_ARGL; end
                P_ARGL: begin argl_d = bd; ps_d = P_CHK;  end
                default: ps_d = P_SOF;
            endcase
        end else if (to_q == TW'(TO_MAX)) ps_d = P_SOF;
    end

    // gap timer only advances while no byte is being received
    assign to_d = (bv || ps_q == P_SOF) ? '0 : rx_idle ? to_q + TW'(1) : to_q;

    // a frame completing in the accept cycle replaces the held one without overflow
    assign load    = frame_done && (!valid_q || cmd_ready);
    assign valid_d = load | (valid_q & ~cmd_ready);
    assign ovf_d   = ovf_q | (frame_done & valid_q & ~cmd_ready);
    assign code_d  = load ? cmd_q : code_q;
    assign arg_d   = load ? {argh_q, argl_q} : arg_q;
    assign fcnt_d  = (fe && fcnt_q != 8'hFF) ? fcnt_q + 8'd1 : fcnt_q;
    assign ccnt_d  = (chk_bad && ccnt_q != 8'hFF) ? ccnt_q + 8'd1 : ccnt_q;

    always_ff @(posedge free_clk or negedge rst_board) begin
        if (!rst_board) begin
            ps_q    <= P_SOF;
            cmd_q   <= '0;
            argh_q  <= '0;
            argl_q  <= '0;
            to_q    <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            code_q  <= '0;
            arg_q   <= '0;
            fcnt_q  <= '0;
            ccnt_q  <= '0;
        end else begin
            ps_q    <= ps_d;
            cmd_q   <= cmd_d;
            argh_q  <= argh_d;
            argl_q  <= argl_d;
            to_q    <= to_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            code_q  <= code_d;
            arg_q   <= arg_d;
            fcnt_q  <= fcnt_d;
            ccnt_q  <= ccnt_d;
        end
    end

    assign cmd_valid     = valid_q;
    assign cmd_code      = code_q;
    assign cmd_arg       = arg_q;
    assign rx_busy       = ps_q != P_SOF;
    assign err_frame_cnt = fcnt_q;
    assign err_chk_cnt   = ccnt_q;
    assign overflow      = ovf_q;
endmodule

// File: tb/tb_ddr_test_uart_cmd.sv
// tb_ddr_test_uart_cmd: randomized self-checking bench against a frame-level reference model
module tb_ddr_test_uart_cmd;
    localparam int CPB = 16;
    localparam int TOB = 20;

    logic        clk = 1'b0, rst_n = 1'b0, rxd = 1'b1, ready = 1'b1;
    logic        cmd_valid, rx_busy, overflow;
    logic [7:0]  cmd_code, err_frame_cnt, err_chk_cnt;
    logic [15:0] cmd_arg;

    ddr_test_uart_cmd #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
        .free_clk     (clk),
        .rst_board    (rst_n),
        .uart_rxd     (rxd),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (ready),
        .cmd_code     (cmd_code),
        .cmd_arg      (cmd_arg),
        .rx_busy      (rx_busy),
        .err_frame_cnt(err_frame_cnt),
        .err_chk_cnt  (err_chk_cnt),
        .overflow     (overflow)
    );

    always #10 clk = ~clk;

    int          total = 0, bad = 0;
    logic [23:0] got_q[$], exp_q[$];
    int          exp_fe = 0, exp_ce = 0;
    bit          exp_ovf = 0, exp_held = 0;
    logic [23:0] held_val = '0;

    always @(negedge clk) if (cmd_valid && ready) got_q.push_back({cmd_code, cmd_arg});

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        rxd = 1'b0;
        cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            cyc(CPB);
        end
        rxd = stop_ok;
        cyc(CPB);
        rxd = 1'b1;
        if (!stop_ok) cyc(CPB);
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] ah, input logic [7:0] al,
                              input logic [7:0] chk, input int bad_idx, input int glitch_idx);
        logic [7:0] fr[5];
        fr = '{8'hA5, c, ah, al, chk};
        for (int i = 0; i < 5; i++) begin
            send_byte(fr[i], i != bad_idx);
            if (i == bad_idx) break;
            if (i == glitch_idx) begin
                rxd = 1'b0;
                cyc(5);
                rxd = 1'b1;
                cyc(CPB);
            end
        end
        if (bad_idx >= 0) exp_fe = exp_fe < 255 ? exp_fe + 1 : 255;
        else if (chk != (c ^ ah ^ al)) exp_ce = exp_ce < 255 ? exp_ce + 1 : 255;
        else if (ready) exp_q.push_back({c, ah, al});
        else if (exp_held) exp_ovf = 1;
        else begin
            exp_held = 1;
            held_val = {c, ah, al};
        end
        cyc(3);
    endtask

    task automatic set_ready(input bit r);
        ready = r;
        if (r && exp_held) begin
            exp_q.push_back(held_val);
            exp_held = 0;
        end
    endtask

    task automatic check_all(input string tag);
        check($sformatf("%s.ncmd", tag), got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0)
            check($sformatf("%s.cmd", tag), got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
        check($sformatf("%s.fe", tag), err_frame_cnt, exp_fe);
        check($sformatf("%s.ce", tag), err_chk_cnt, exp_ce);
        check($sformatf("%s.ovf", tag), overflow, exp_ovf);
        check($sformatf("%s.valid", tag), cmd_valid, exp_held);
        check($sformatf("%s.busy", tag), rx_busy, 0);
        if (exp_held) check($sformatf("%s.held", tag), {cmd_code, cmd_arg}, held_val);
    endtask

    task automatic reset_chk(input string tag);
        check($sformatf("%s.valid", tag), cmd_valid, 0);
        check($sformatf("%s.code", tag), cmd_code, 0);
        check($sformatf("%s.arg", tag), cmd_arg, 0);
        check($sformatf("%s.busy", tag), rx_busy, 0);
        check($sformatf("%s.fe", tag), err_frame_cnt, 0);
        check($sformatf("%s.ce", tag), err_chk_cnt, 0);
        check($sformatf("%s.ovf", tag), overflow, 0);
    endtask

    initial begin
        logic [7:0] c, ah, al, chk;
        int kind, bi, gi;
        cyc(3);
        #5 rst_n = 1'b1;
        cyc(2);
        reset_chk("reset");

        send_frame(8'h01, 8'h12, 8'h34, 8'h27, -1, -1);
        check_all("basic");

        send_frame(8'h01, 8'h12, 8'h34, 8'h28, -1, -1);
        send_frame(8'h02, 8'h56, 8'h78, 8'h02 ^ 8'h56 ^ 8'h78, -1, -1);
        check_all("chk_err");

        send_frame(8'h03, 8'hAB, 8'hCD, 8'h03 ^ 8'hAB ^ 8'hCD, 2, -1);
        send_frame(8'h04, 8'h9A, 8'hBC, 8'h04 ^ 8'h9A ^ 8'hBC, -1, -1);
        check_all("stop_err");

        set_ready(0);
        send_frame(8'h11, 8'h22, 8'h33, 8'h11 ^ 8'h22 ^ 8'h33, -1, -1);
        send_frame(8'h44, 8'h55, 8'h66, 8'h44 ^ 8'h55 ^ 8'h66, -1, -1);
        check_all("ovf");
        set_ready(1);
        cyc(1);
        check("valid_drop", cmd_valid, 0);
        check_all("ovf_rel");

        send_byte(8'hA5, 1);
        send_byte(8'h01, 1);
        cyc(2);
        check("partial_busy", rx_busy, 1);
        cyc(25 * CPB);
        check("timeout_busy", rx_busy, 0);
        send_frame(8'h05, 8'hAA, 8'h55, 8'h05 ^ 8'hAA ^ 8'h55, -1, -1);
        check_all("timeout");

        send_frame(8'h06, 8'h0F, 8'hF0, 8'h06 ^ 8'h0F ^ 8'hF0, -1, 1);
        check_all("glitch");

        send_byte(8'hA5, 1);
        send_byte(8'h07, 1);
        send_byte(8'h12, 1);
        rxd = 1'b0;
        cyc(CPB);
        rxd = 1'b1;
        cyc(CPB / 2);
        #3 rst_n = 1'b0;
        #50 rst_n = 1'b1;
        exp_fe = 0;
        exp_ce = 0;
        exp_ovf = 0;
        exp_held = 0;
        got_q.delete();
        cyc(2);
        reset_chk("rst_mid");
        send_frame(8'h08, 8'h34, 8'h56, 8'h08 ^ 8'h34 ^ 8'h56, -1, -1);
        check_all("after_rst");

        for (int n = 0; n < 24; n++) begin
            kind = $urandom_range(0, 9);
            c = 8'($urandom);
            ah = 8'($urandom);
            al = 8'($urandom);
            chk = c ^ ah ^ al;
            bi = -1;
            gi = -1;
            if (kind < 2) chk = chk ^ 8'($urandom_range(1, 255));
            else if (kind < 4) bi = $urandom_range(0, 4);
            if (kind == 9) gi = $urandom_range(0, 3);
            send_frame(c, ah, al, chk, bi, gi);
            cyc($urandom_range(0, 3 * CPB));
            check_all($sformatf("rand%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ddr_test_uart_cmd.md
# ddr_test_uart_cmd

UART command front-end of the DDR test design: receives 8N1 serial bytes on `uart_rxd`, assembles 5-byte checksummed command frames and presents each valid frame as a single ready/valid command to the DDR test controller. It sits directly downstream of the board UART pin and upstream of the DDR traffic/check engine, running on `free_clk` (50 MHz).

## Interface
Parameters:
- `CLKS_PER_BIT`, 434, `free_clk` cycles per UART bit (50 MHz / 115200).
- `TIMEOUT_BITS`, 20, max idle gap in bit periods between bytes of one frame.

Ports:
- `free_clk`  in  1  sole clock.
- `rst_board`  in  1  asynchronous, active-low reset.
- `uart_rxd`  in  1  asynchronous serial input, idle high.
- `cmd_valid`  out  1  command held, awaiting acceptance.
- `cmd_ready`  in  1  consumer accepts when `cmd_valid & cmd_ready`.
- `cmd_code`  out  8  command byte.
- `cmd_arg`  out  16  argument, `{ARG_H, ARG_L}`.
- `rx_busy`  out  1  parser is mid-frame (not in P_SOF).
- `err_frame_cnt`  out  8  stop-bit errors, saturating at 255.
- `err_chk_cnt`  out  8  checksum errors, saturating at 255.
- `overflow`  out  1  sticky: a good frame was dropped because `cmd_valid` was still high.

Reset values: `cmd_valid`=0, `cmd_code`=0, `cmd_arg`=0, `rx_busy`=0, both counters 0, `overflow`=0. Internal synchronizer flops reset to 1.

## Operation
- `uart_rxd` passes through a 2-FF synchronizer (reset 1). Edge detection uses the synchronized signal.
- Byte receiver FSM:
  - R_IDLE: on a synchronized falling edge, load the bit counter and go to R_START.
  - R_START: at `CLKS_PER_BIT/2` (integer divide), sample. If the sample is 1 (glitch), return to R_IDLE. Otherwise go to R_DATA.
  - R_DATA: 8 samples, each `CLKS_PER_BIT` apart. LSB first.
  - R_STOP: one sample. If it is 1, pulse `byte_valid` for one cycle with the byte. If it is 0, pulse `frame_err` and discard the byte.
  - After the stop sample, return to R_IDLE immediately; no wait for the end of the stop bit.
- Frame format: `0xA5`, CMD, ARG_H, ARG_L, CHK, where CHK = CMD ^ ARG_H ^ ARG_L.
- Parser FSM: P_SOF → P_CMD → P_ARGH → P_ARGL → P_CHK → P_SOF.
  - In P_SOF, any byte other than 0xA5 is ignored.
  - Correct CHK: the frame is delivered.
  - Wrong CHK: `err_chk_cnt`+1, return to P_SOF.
- A `frame_err` in any parser state: `err_frame_cnt`+1, parser returns to P_SOF.
- Inter-byte timeout: the counter runs while the parser is not in P_SOF and the byte FSM is in R_IDLE. It clears on every `byte_valid`. At `TIMEOUT_BITS*CLKS_PER_BIT` cycles the parser returns to P_SOF. No counter increments on timeout.
- Delivery uses a one-entry holding register.
  - If `cmd_valid`=0, load the register and set `cmd_valid`.
  - If `cmd_valid`=1 and `cmd_ready`=0 in the same cycle, drop the new frame and set `overflow`.
  - If `cmd_valid & cmd_ready` and a new frame completes in the same cycle, the new frame replaces the held one. `cmd_valid` stays 1 and there is no overflow.
- `cmd_code`/`cmd_arg` are stable while `cmd_valid`=1. `cmd_valid` deasserts the cycle after acceptance unless it is replaced.

## Timing
- Sample points fall at synchronized falling edge + `CLKS_PER_BIT/2` + k·`CLKS_PER_BIT`, k = 0..9.
- `byte_valid` occurs 1 cycle after the stop sample.
- `cmd_valid` rises 1 cycle after the CHK `byte_valid`. With `CLKS_PER_BIT`=434, one byte ≈ 4340 cycles.
- Reset asserted mid-byte or mid-frame discards all partial state at once. The first falling edge after release starts a new byte.
- `cmd_ready` may be held high permanently. `cmd_valid` is then a 1-cycle pulse per frame.

## Structure
- Package `ddr_test_uart_pkg` holds:
  - the SOF constant `8'hA5`;
  - command code constants (START=0x01, STOP=0x02, SET_PATTERN=0x03, CLR_ERR=0x04);
  - the receiver and parser state enumerations.
- Sub-module `uart_rx_byte` contains the synchronizer, the byte FSM and the bit/baud counters. It outputs `byte_valid`, `byte_data`, `frame_err` and `idle`.
- The top level contains the parser, the timeout counter, the holding register and the error counters.

## Test plan
- Frame A5 01 12 34 27 at 434 cycles/bit, `cmd_ready`=1 → one `cmd_valid` pulse with `cmd_code`=0x01 and `cmd_arg`=0x1234. Counters stay 0.
- Same frame with CHK=0x28 → no `cmd_valid`, `err_chk_cnt`=1. The next correct frame is still delivered.
- Third byte sent with its stop bit forced 0 → `err_frame_cnt`=1, frame discarded. The following good frame decodes.
- Two good frames with `cmd_ready`=0 → first frame held unchanged, second dropped, `overflow`=1. Raising `cmd_ready` deasserts `cmd_valid` the next cycle.
- A5 01 sent, then idle for 25 bit periods, then a full good frame → the stale partial frame is abandoned and only the new frame is delivered. A 200-cycle low glitch on `uart_rxd` produces no byte.
- `rst_board` pulsed low for 50 ns during ARG_L → all outputs return to reset values. A complete frame sent after release decodes correctly.
